fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, 32'd0, first fetch byte address.
REQ-002 SHALL have parameter IMEM_BYTES, 32, size of the instruction store window in bytes; fetch at or beyond it is end-of-program.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  load-use hold from hazard unit.
REQ-006 SHALL have port redirect_valid  input  1  taken branch/jump this cycle.
REQ-007 SHALL have port redirect_pc  input  32  branch/jump target byte address.
REQ-008 SHALL have port instruction  input  32  word returned combinationally by instruction memory for pc.
REQ-009 SHALL have port pc  output  32  fetch address driven to instruction memory.
REQ-010 SHALL have port if_id_instr  output  32  IF/ID instruction register.
REQ-011 SHALL have port if_id_pc4  output  32  IF/ID pc+4 register.
REQ-012 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction.
REQ-013 SHALL have port halted  output  1  high while in HALT state.
REQ-014 SHALL have port fetch_count  output  16  saturating count of instructions loaded into IF/ID.

Function
REQ-015 SHALL implement states BOOT, RUN, HALT; BOOT lasts exactly one cycle, then RUN.
REQ-016 In BOOT, pc SHALL hold RESET_PC and IF/ID SHALL stay invalid.
REQ-017 In RUN with redirect_valid=0, stall=0, pc<IMEM_BYTES: IF/ID SHALL load {instruction, pc+4, valid=1}, pc SHALL become pc+4, and fetch_count SHALL increment.
REQ-018 In RUN with stall=1 and redirect_valid=0, pc, IF/ID and fetch_count SHALL hold.
REQ-019 redirect_valid=1 SHALL take priority over stall in RUN and HALT.
REQ-020 On redirect, pc SHALL become {redirect_pc[31:2],2'b00}.
REQ-021 On redirect, IF/ID SHALL be flushed: instr=0, pc4=0, valid=0.
REQ-022 On redirect, fetch_count SHALL hold.
REQ-023 On redirect, the state SHALL be RUN.
REQ-024 In RUN with pc>=IMEM_BYTES and no redirect, IF/ID SHALL be flushed, pc SHALL hold, and the next state SHALL be HALT.
REQ-025 In HALT, pc and IF/ID SHALL hold, and only redirect or reset SHALL leave HALT.
REQ-026 A redirect to an address >=IMEM_BYTES SHALL enter RUN, then HALT one cycle later per REQ-024.
REQ-027 pc+4 SHALL wrap modulo 2^32.
REQ-028 fetch_count SHALL saturate at 16'hFFFF.
REQ-029 pc SHALL be a registered output only, with no combinational path from inputs to pc.

Reset
REQ-030 reset=1 at a clock edge SHALL set pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0, fetch_count=0, state=BOOT.
REQ-031 reset SHALL override stall and redirect_valid.
REQ-032 Mid-operation reset SHALL discard any pending redirect.

Structure
REQ-033 State encoding, NOP word (32'd0) and the word-size constant 4 SHALL live in the shared pipeline package.
REQ-034 The saturating fetch counter SHALL be the single sub-module, sat_counter, with a width parameter.

Verification
REQ-035 Reset released, no stall, IMEM_BYTES=32 -> pc 0,0,4,8,...,28,32; if_id_valid high for 8 loads; halted rises the cycle after pc=32; fetch_count=8.
REQ-036 stall=1 for 2 cycles at pc=8 -> pc stays 8 and IF/ID unchanged for 2 cycles; the next load captures the word at 8.
REQ-037 redirect_valid=1 with redirect_pc=0x13 together with stall=1 -> pc=0x10 next cycle, if_id_valid=0, if_id_instr=0, fetch_count unchanged.
REQ-038 In HALT, redirect to 0x4 -> halted=0 and pc=4 next cycle; fetching resumes at 4.
REQ-039 Force fetch_count to 16'hFFFE and load 3 instructions -> fetch_count=16'hFFFF.
REQ-040 Assert reset during a redirect cycle -> pc=RESET_PC, state BOOT, all IF/ID fields 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: fetch state encoding and pipeline constants shared by the fetch stage
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  localparam logic [31:0] NOP = 32'd0;
  localparam logic [31:0] WORD_BYTES = 32'd4;
endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    count <= reset ? '0 : (en && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch FSM driving pc and the IF/ID register
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] IMEM_BYTES = 32'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);
  state_t state;
  logic redir, eop, load;
  // BOOT ignores redirects so it always lasts exactly one cycle
  always_comb begin
    redir = redirect_valid && state != BOOT;
    eop   = state == RUN && !redir && pc >= IMEM_BYTES;
    load  = state == RUN && !redir && !stall && pc < IMEM_BYTES;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_instr <= NOP;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (redir) begin
      state       <= RUN;
      pc          <= redirect_pc & ~(WORD_BYTES - 32'd1);
      if_id_instr <= NOP;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (state == BOOT) begin
      state <= RUN;
    end else if (eop) begin
      state       <= HALT;
      if_id_instr <= NOP;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b1;
    end else if (load) begin
      pc          <= pc + WORD_BYTES;
      if_id_instr <= instruction;
      if_id_pc4   <= pc + WORD_BYTES;
      if_id_valid <= 1'b1;
    end
  end
  sat_counter #(.W(16)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (load),
    .count(fetch_count)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized and directed checks of fetch_ctrl against a behavioural model
module tb_fetch_ctrl;
  logic clk = 0, reset = 1, stall = 0, redirect_valid = 0;
  logic [31:0] redirect_pc = 0, instruction, pc, if_id_instr, if_id_pc4;
  logic if_id_valid, halted;
  logic [15:0] fetch_count;
  logic reset2 = 1;
  logic [31:0] instruction2, pc2, if_id_instr2, if_id_pc42;
  logic if_id_valid2, halted2;
  logic [15:0] fetch_count2;
  logic [31:0] mem [8];
  logic [31:0] m_pc, m_i, m_p4;
  logic m_v, m_halt, m_boot;
  logic [15:0] m_cnt;
  logic [113:0] obs;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign instruction  = mem[pc[4:2]];
  assign instruction2 = ~pc2;
  assign obs = {pc, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count};

  fetch_ctrl #(.RESET_PC(32'd0), .IMEM_BYTES(32'd32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instruction(instruction), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count));

  fetch_ctrl #(.RESET_PC(32'd0), .IMEM_BYTES(32'h0010_0000)) dut2 (
    .clk(clk), .reset(reset2), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'd0), .instruction(instruction2), .pc(pc2),
    .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc42), .if_id_valid(if_id_valid2),
    .halted(halted2), .fetch_count(fetch_count2));

  function automatic logic [113:0] exp_vec();
    return {m_pc, m_i, m_p4, m_v, m_halt, m_cnt};
  endfunction

  // one clock edge; the model follows the fetch rules for the inputs seen at that edge
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      m_boot = 1; m_halt = 0; m_pc = 0; m_i = 0; m_p4 = 0; m_v = 0; m_cnt = 0;
    end else if (m_boot) m_boot = 0;
    else if (redirect_valid) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC; m_i = 0; m_p4 = 0; m_v = 0; m_halt = 0;
    end else if (!m_halt && m_pc >= 32) begin
      m_i = 0; m_p4 = 0; m_v = 0; m_halt = 1;
    end else if (!m_halt && !stall) begin
      m_i = mem[m_pc[4:2]]; m_p4 = m_pc + 4; m_v = 1; m_pc = m_pc + 4;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; stall = 1; redirect_valid = 1; redirect_pc = 32'h44;
    cycle();
    checks++;
    if (obs !== 114'd0) begin errors++; $display("FAIL reset: got %h want 0", obs); end
    stall = 0; redirect_valid = 0;
  endtask

  task automatic test_sequential();
    reset = 1; cycle(); reset = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      checks++;
      if (pc !== ((i < 2) ? 32'd0 : (i > 9) ? 32'd32 : 32'(4 * (i - 1))) || halted !== (i == 10) || obs !== exp_vec()) begin
        errors++; $display("FAIL sequential c%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (fetch_count !== 16'd8 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL seq_count: got cnt %0d valid %b want 8 0", fetch_count, if_id_valid);
    end
  endtask

  task automatic test_stall();
    reset = 1; cycle(); reset = 0;
    repeat (3) cycle();
    stall = 1;
    repeat (2) begin
      cycle();
      checks++;
      if (pc !== 32'd8 || if_id_instr !== mem[1] || if_id_pc4 !== 32'd8 || if_id_valid !== 1'b1 || obs !== exp_vec()) begin
        errors++; $display("FAIL stall_hold: got pc %h instr %h want 8 %h", pc, if_id_instr, mem[1]);
      end
    end
    stall = 0; cycle();
    checks++;
    if (if_id_instr !== mem[2] || if_id_pc4 !== 32'd12 || pc !== 32'd12 || obs !== exp_vec()) begin
      errors++; $display("FAIL stall_resume: got instr %h pc4 %h want %h 12", if_id_instr, if_id_pc4, mem[2]);
    end
  endtask

  task automatic test_redirect_stall();
    logic [15:0] saved;
    saved = fetch_count;
    redirect_valid = 1; redirect_pc = 32'h13; stall = 1;
    cycle();
    checks++;
    if (pc !== 32'h10 || if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_pc4 !== 32'd0 || fetch_count !== saved || obs !== exp_vec()) begin
      errors++; $display("FAIL redirect_stall: got %h want pc 10 cnt %0d", obs, saved);
    end
    redirect_valid = 0; stall = 0;
  endtask

  task automatic test_halt_redirect();
    int n = 0;
    while (!halted && n < 20) begin
      cycle(); n++;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL run_to_halt: got %h want %h", obs, exp_vec()); end
    end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_timeout: halted %b want 1", halted); end
    redirect_valid = 1; redirect_pc = 32'h4;
    cycle();
    checks++;
    if (halted !== 1'b0 || pc !== 32'd4 || obs !== exp_vec()) begin
      errors++; $display("FAIL halt_redirect: got halted %b pc %h want 0 4", halted, pc);
    end
    redirect_valid = 0; cycle();
    checks++;
    if (if_id_instr !== mem[1] || pc !== 32'd8 || obs !== exp_vec()) begin
      errors++; $display("FAIL halt_resume: got instr %h pc %h want %h 8", if_id_instr, pc, mem[1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 10);
      redirect_pc = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 44);
      cycle();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random c%0d: got %h want %h", i, obs, exp_vec()); end
    end
    reset = 0; stall = 0; redirect_valid = 0;
  endtask

  task automatic test_reset_redirect();
    reset = 1; cycle(); reset = 0;
    repeat (4) cycle();
    reset = 1; redirect_valid = 1; redirect_pc = 32'h18;
    cycle();
    checks++;
    if (obs !== 114'd0) begin errors++; $display("FAIL reset_redirect: got %h want 0", obs); end
    reset = 0; redirect_valid = 0;
    repeat (2) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL post_reset: got %h want %h", obs, exp_vec()); end
    end
    checks++;
    if (pc !== 32'd4 || if_id_instr !== mem[0]) begin
      errors++; $display("FAIL post_reset_fetch: got pc %h instr %h want 4 %h", pc, if_id_instr, mem[0]);
    end
  endtask

  task automatic test_saturation();
    reset = 1;
    reset2 = 1; @(posedge clk); #1; reset2 = 0;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    checks++;
    if (fetch_count2 !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", fetch_count2); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fetch_count2 !== 16'hFFFF || pc2 !== 32'h0004_0004 || if_id_instr2 !== ~32'h0004_0000) begin
      errors++; $display("FAIL sat: got cnt %h pc %h want ffff 40004", fetch_count2, pc2);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_halt_redirect();
    test_random();
    test_reset_redirect();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
